seq_pattern_counter: RTL and testbench

SEQ_PATTERN_COUNTER -- requirements
Module: seq_pattern_counter

---
 rtl/seq_pkg.sv | 12 +
 rtl/sat_counter.sv | 40 ++++
 rtl/seq_pattern_counter.sv | 73 +++++++
 tb/tb_seq_pattern_counter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared defaults and helpers for the serial pattern counter.
// Imported by the counter top and its saturating sub-counter.
package seq_pkg;

    localparam int PAT_W_DEF = 3;
    localparam int CNT_W_DEF = 8;

    function automatic int cnt_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky overflow flag.
// An increment at the maximum leaves q unchanged and raises sat.
module sat_counter
    import seq_pkg::*;
#(
    parameter int WIDTH = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(cnt_max(WIDTH));

    logic [WIDTH-1:0] r_q;
    logic             r_sat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q   <= '0;
            r_sat <= 1'b0;
        end else if (clr) begin
            r_q   <= '0;
            r_sat <= 1'b0;
        end else if (inc) begin
            if (r_q == MAX) begin
                r_sat <= 1'b1;
            end else begin
                r_q <= r_q + 1'b1;
            end
        end
    end

    assign q   = r_q;
    assign sat = r_sat;

endmodule

// File: rtl/seq_pattern_counter.sv
// Serial bit-pattern detector with overlap control and a saturating
// occurrence counter; all outputs are registered.
module seq_pattern_counter
    import seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic             din,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap_en,
    input  logic             clear,
    output logic             match,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);
    localparam logic [FW-1:0] FILL_THR  = FW'(PAT_W - 1);

    logic [PAT_W-1:0] r_sr;
    logic [FW-1:0]    r_fill;
    logic             r_match;

    logic [PAT_W-1:0] w_win;
    logic             w_accept;
    logic             w_hit;

    assign w_win    = {r_sr[PAT_W-2:0], din};
    assign w_accept = din_valid & ~clear;
    // fill+1 >= PAT_W, written without the carry into an extra bit
    assign w_hit    = w_accept && (r_fill >= FILL_THR) && (w_win == pattern);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sr    <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else if (clear) begin
            r_sr    <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else begin
            r_match <= w_hit;
            if (din_valid) begin
                r_sr <= w_win;
                if (w_hit && !overlap_en) begin
                    r_fill <= '0;
                end else if (r_fill != FILL_FULL) begin
                    r_fill <= r_fill + 1'b1;
                end
            end
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (w_hit),
        .clr  (clear),
        .q    (count),
        .sat  (sat)
    );

    assign match = r_match;

endmodule

// File: tb/tb_seq_pattern_counter.sv
// Directed bench: default 3-bit instance plus a 2-bit/2-bit instance
// for counter saturation.
module tb_seq_pattern_counter;

    logic       clk;
    logic       rst_n;
    logic       din_valid;
    logic       din;
    logic [2:0] pattern;
    logic       overlap_en;
    logic       clear;
    logic       match;
    logic [7:0] count;
    logic       sat;

    logic       din_valid2;
    logic       din2;
    logic [1:0] pattern2;
    logic       clear2;
    logic       match2;
    logic [1:0] count2;
    logic       sat2;

    int n_cmp = 0;
    int n_bad = 0;

    seq_pattern_counter #(.PAT_W(3), .CNT_W(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din_valid (din_valid),
        .din       (din),
        .pattern   (pattern),
        .overlap_en(overlap_en),
        .clear     (clear),
        .match     (match),
        .count     (count),
        .sat       (sat)
    );

    seq_pattern_counter #(.PAT_W(2), .CNT_W(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .din_valid (din_valid2),
        .din       (din2),
        .pattern   (pattern2),
        .overlap_en(1'b1),
        .clear     (clear2),
        .match     (match2),
        .count     (count2),
        .sat       (sat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one edge on the 3-bit instance; returns #1 after the edge.
    task automatic drive(input logic v, input logic d);
        @(negedge clk);
        din_valid = v;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic v, input logic d);
        @(negedge clk);
        din_valid2 = v;
        din2       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        drive(1'b0, 1'b0);
        @(negedge clk);
        clear = 1'b0;
    endtask

    logic [15:0] stream;
    logic [15:0] exp_ov;
    logic [15:0] exp_nov;
    logic [15:0] exp_m;
    logic [5:0]  exp2_m;
    logic [11:0] exp2_c;
    logic [5:0]  exp2_s;
    int          gap;

    initial begin
        stream  = 16'b1011011011010101;
        exp_ov  = 16'b0010010010010101;
        exp_nov = 16'b0010010010010001;
        exp2_m  = 6'b011111;
        exp2_c  = {2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        exp2_s  = 6'b000011;

        rst_n      = 1'b0;
        din_valid  = 1'b0;
        din        = 1'b0;
        pattern    = 3'b101;
        overlap_en = 1'b1;
        clear      = 1'b0;
        din_valid2 = 1'b0;
        din2       = 1'b0;
        pattern2   = 2'b11;
        clear2     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_match", 32'(match), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        check("rst_count2", 32'(count2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous stream, overlapping then non-overlapping
        for (int ov = 1; ov >= 0; ov--) begin
            overlap_en = 1'(ov);
            exp_m = (ov == 1) ? exp_ov : exp_nov;
            for (int i = 0; i < 16; i++) begin
                drive(1'b1, stream[15-i]);
                check($sformatf("match_ov%0d_b%0d", ov, i),
                      32'(match), 32'(exp_m[15-i]));
            end
            drive(1'b0, 1'b0);
            check($sformatf("count_ov%0d", ov), 32'(count),
                  (ov == 1) ? 32'd6 : 32'd5);
            check("match_idle", 32'(match), 32'd0);
            do_clear();
            check("count_clr", 32'(count), 32'd0);
        end

        // Same stream with random invalid gaps
        for (int ov = 1; ov >= 0; ov--) begin
            overlap_en = 1'(ov);
            exp_m = (ov == 1) ? exp_ov : exp_nov;
            for (int i = 0; i < 16; i++) begin
                if (i != 0) begin
                    gap = $urandom_range(1, 3);
                    for (int g = 0; g < gap; g++) begin
                        drive(1'b0, 1'($urandom));
                        check("match_gap", 32'(match), 32'd0);
                    end
                end
                drive(1'b1, stream[15-i]);
                check($sformatf("gmatch_ov%0d_b%0d", ov, i),
                      32'(match), 32'(exp_m[15-i]));
            end
            drive(1'b0, 1'b0);
            check($sformatf("gcount_ov%0d", ov), 32'(count),
                  (ov == 1) ? 32'd6 : 32'd5);
            do_clear();
        end

        // Saturation on the 2-bit instance: six consecutive ones
        for (int i = 0; i < 6; i++) begin
            drive2(1'b1, 1'b1);
            check($sformatf("m2_b%0d", i), 32'(match2),
                  32'(exp2_m[5-i]));
            check($sformatf("c2_b%0d", i), 32'(count2),
                  32'(exp2_c[(5-i)*2 +: 2]));
            check($sformatf("s2_b%0d", i), 32'(sat2),
                  32'(exp2_s[5-i]));
        end
        drive2(1'b0, 1'b0);
        check("m2_idle", 32'(match2), 32'd0);
        check("s2_sticky", 32'(sat2), 32'd1);

        // Clear discards history and the bit accepted with it
        overlap_en = 1'b1;
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        @(negedge clk);
        clear = 1'b1;
        drive(1'b1, 1'b1);
        check("clr_match", 32'(match), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        drive(1'b1, 1'b1);
        check("clr_after1", 32'(match), 32'd0);
        drive(1'b1, 1'b0);
        check("clr_after0", 32'(match), 32'd0);
        drive(1'b1, 1'b1);
        check("clr_hit", 32'(match), 32'd1);
        check("clr_count", 32'(count), 32'd1);
        do_clear();

        // Reset mid-stream
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b1, 1'b0);
        check("mrst_match", 32'(match), 32'd0);
        check("mrst_count", 32'(count), 32'd0);
        check("mrst_sat", 32'(sat), 32'd0);
        check("mrst_sat2", 32'(sat2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1);
        check("mrst_b0", 32'(match), 32'd0);
        drive(1'b1, 1'b0);
        check("mrst_b1", 32'(match), 32'd0);
        drive(1'b1, 1'b1);
        check("mrst_b2", 32'(match), 32'd1);
        drive(1'b0, 1'b0);
        check("mrst_count1", 32'(count), 32'd1);
        check("mrst_idle", 32'(match), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
